// File: rtl/ysyx_25030085_lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Exports RV32I funct3 width codes and the LSU FSM state type.
package ysyx_25030085_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/ysyx_25030085_lsu_if.sv
// Data-memory valid/ready bus between the LSU and memory.
// master: LSU drives req_*; slave: memory drives req_ready and resp_*.
interface ysyx_25030085_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_addr,
        output req_wen,
        output req_wmask,
        output req_wdata,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_addr,
        input  req_wen,
        input  req_wmask,
        input  req_wdata,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/ysyx_25030085_lsu_align.sv
// Combinational legality/alignment check, store lane shift, load extend.
// Ports: funct3, is_load, off (addr[1:0]), wdata, rdata -> ok, wmask, wdata_sh, rdata_ext.
module ysyx_25030085_lsu_align
    import ysyx_25030085_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        ok,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic        legal;
    logic        aligned;
    logic [31:0] sh;

    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            funct3 == F3_B,
            funct3 == F3_H,
            funct3 == F3_W:  legal = 1'b1;
            funct3 == F3_BU,
            funct3 == F3_HU: legal = is_load;
            default:         legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes width: 00 byte, 01 half, 10 word.
    always_comb begin
        aligned = 1'b0;
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign ok = legal && aligned;

    always_comb begin
        wmask    = 4'b0000;
        wdata_sh = '0;
        case (funct3[1:0])
            2'b00: begin
                wmask    = 4'b0001 << off;
                wdata_sh = {4{wdata[7:0]}};
            end
            2'b01: begin
                wmask    = 4'b0011 << off;
                wdata_sh = {2{wdata[15:0]}};
            end
            2'b10: begin
                wmask    = 4'b1111;
                wdata_sh = wdata;
            end
            default: begin
                wmask    = 4'b0000;
                wdata_sh = '0;
            end
        endcase
    end

    assign sh = rdata >> {off, 3'b000};

    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{sh[7]}}, sh[7:0]};
            F3_H:    rdata_ext = {{16{sh[15]}}, sh[15:0]};
            F3_W:    rdata_ext = rdata;
            F3_BU:   rdata_ext = {24'h0, sh[7:0]};
            F3_HU:   rdata_ext = {16'h0, sh[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: one data-memory transaction per memory instruction.
// Ports: clk/rst, execute inputs, writeback outputs, bus (master modport).
module ysyx_25030085_lsu
    import ysyx_25030085_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_busy,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic        lsu_err,
    ysyx_25030085_lsu_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t      state;
    logic [CW-1:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        load_q;

    logic        idle;
    logic [2:0]  f3_sel;
    logic [1:0]  off_sel;
    logic        ld_sel;
    logic        ok;
    logic [3:0]  wmask;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_ext;

    // One align instance: live inputs while idle, latched access otherwise.
    assign idle    = (state == IDLE);
    assign f3_sel  = idle ? funct3    : f3_q;
    assign off_sel = idle ? addr[1:0] : off_q;
    assign ld_sel  = idle ? mem_read  : load_q;

    ysyx_25030085_lsu_align u_align (
        .funct3    (f3_sel),
        .is_load   (ld_sel),
        .off       (off_sel),
        .wdata     (wdata),
        .rdata     (bus.resp_rdata),
        .ok        (ok),
        .wmask     (wmask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    // Freeze the instruction in the same cycle it is presented.
    assign lsu_busy = !idle || ex_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            load_q        <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rdata      <= '0;
            lsu_err       <= 1'b0;
            bus.req_valid <= 1'b0;
            bus.req_addr  <= '0;
            bus.req_wen   <= 1'b0;
            bus.req_wmask <= '0;
            bus.req_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wb_valid <= 1'b0;
                    wb_rdata <= '0;
                    lsu_err  <= 1'b0;
                    if (ex_valid) begin
                        if ((mem_read ^ mem_write) && ok) begin
                            f3_q          <= funct3;
                            off_q         <= addr[1:0];
                            load_q        <= mem_read;
                            bus.req_valid <= 1'b1;
                            bus.req_addr  <= {addr[31:2], 2'b00};
                            bus.req_wen   <= mem_write;
                            bus.req_wmask <= mem_write ? wmask : 4'b0000;
                            bus.req_wdata <= mem_write ? wdata_sh : '0;
                            state         <= REQ;
                        end else begin
                            wb_valid <= 1'b1;
                            lsu_err  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus.req_ready) begin
                        bus.req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.resp_valid) begin
                        wb_valid <= 1'b1;
                        lsu_err  <= bus.resp_err;
                        wb_rdata <= (load_q && !bus.resp_err) ? rdata_ext : '0;
                        state    <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th silent WAIT cycle.
                        cnt      <= cnt + 1'b1;
                        wb_valid <= 1'b1;
                        lsu_err  <= 1'b1;
                        wb_rdata <= '0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    wb_valid <= 1'b0;
                    wb_rdata <= '0;
                    lsu_err  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Directed bench for the LSU with a writeback scoreboard.
// Drives the bus slave side from the main sequence; TIMEOUT is 4.
module tb_ysyx_25030085_lsu;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lsu_busy;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        lsu_err;

    ysyx_25030085_lsu_if bus ();

    ysyx_25030085_lsu #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .lsu_busy  (lsu_busy),
        .wb_valid  (wb_valid),
        .wb_rdata  (wb_rdata),
        .lsu_err   (lsu_err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
            chk({tag, "_wb_rdata"}, wb_rdata, e.rd);
            chk({tag, "_lsu_err"}, {31'd0, lsu_err}, {31'd0, e.err});
        end
    endtask

    // Present one instruction for one cycle; returns at the next negedge.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        e.rd  = exp_rd;
        e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        ex_valid  = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        chk("busy_on_issue", {31'd0, lsu_busy}, 32'd1);
        @(negedge clk);
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
    endtask

    // Called in the first REQ cycle; finishes one cycle after retire.
    task automatic bus_txn(input string tag, input int stall,
                           input logic [31:0] exp_addr, input logic exp_wen,
                           input logic [3:0] exp_mask,
                           input logic [31:0] exp_wd,
                           input logic [31:0] rsp, input logic rerr);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_req_valid"}, {31'd0, bus.req_valid}, 32'd1);
            chk({tag, "_req_addr"}, bus.req_addr, exp_addr);
            chk({tag, "_req_wen"}, {31'd0, bus.req_wen}, {31'd0, exp_wen});
            chk({tag, "_req_wmask"}, {28'd0, bus.req_wmask}, {28'd0, exp_mask});
            chk({tag, "_req_wdata"}, bus.req_wdata, exp_wd);
            chk({tag, "_busy"}, {31'd0, lsu_busy}, 32'd1);
        end
        bus.req_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_req_drop"}, {31'd0, bus.req_valid}, 32'd0);
        chk({tag, "_no_early_wb"}, {31'd0, wb_valid}, 32'd0);
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rsp;
        bus.resp_err   = rerr;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        pop_check(tag);
        @(negedge clk);
        chk({tag, "_wb_pulse"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, lsu_busy}, 32'd0);
    endtask

    // Accesses that never reach the bus retire in the cycle after issue.
    task automatic local_err(input string tag);
        chk({tag, "_no_req"}, {31'd0, bus.req_valid}, 32'd0);
        pop_check(tag);
        @(negedge clk);
        chk({tag, "_wb_pulse"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_no_req2"}, {31'd0, bus.req_valid}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        ex_valid       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        funct3         = 3'b000;
        addr           = 32'h0;
        wdata          = 32'h0;
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rdata", wb_rdata, 32'd0);
        chk("rst_lsu_err", {31'd0, lsu_err}, 32'd0);
        chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("rst_req_addr", bus.req_addr, 32'd0);
        chk("rst_req_wmask", {28'd0, bus.req_wmask}, 32'd0);
        chk("rst_req_wdata", bus.req_wdata, 32'd0);
        rst = 1'b0;

        issue(1, 0, 3'b010, 32'h8000_0104, 32'h0, 32'hDEAD_BEEF, 0);
        bus_txn("lw", 0, 32'h8000_0104, 0, 4'b0000, 32'h0,
                32'hDEAD_BEEF, 0);

        issue(1, 0, 3'b000, 32'h8000_0103, 32'h0, 32'hFFFF_FF80, 0);
        bus_txn("lb", 0, 32'h8000_0100, 0, 4'b0000, 32'h0,
                32'h80FF_0011, 0);

        issue(1, 0, 3'b100, 32'h8000_0103, 32'h0, 32'h0000_0080, 0);
        bus_txn("lbu", 0, 32'h8000_0100, 0, 4'b0000, 32'h0,
                32'h80FF_0011, 0);

        issue(1, 0, 3'b001, 32'h8000_0102, 32'h0, 32'hFFFF_80FF, 0);
        bus_txn("lh", 0, 32'h8000_0100, 0, 4'b0000, 32'h0,
                32'h80FF_0011, 0);

        issue(1, 0, 3'b101, 32'h8000_0102, 32'h0, 32'h0000_80FF, 0);
        bus_txn("lhu", 0, 32'h8000_0100, 0, 4'b0000, 32'h0,
                32'h80FF_0011, 0);

        issue(0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 0);
        bus_txn("sh", 0, 32'h8000_0000, 1, 4'b1100, 32'hABCD_ABCD,
                32'h0, 0);

        issue(0, 1, 3'b000, 32'h8000_0011, 32'h0000_005A, 32'h0, 0);
        bus_txn("sb", 0, 32'h8000_0010, 1, 4'b0010, 32'h5A5A_5A5A,
                32'h0, 0);

        bus.req_ready = 1'b0;
        issue(0, 1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 0);
        bus_txn("sw_stall", 5, 32'h8000_0020, 1, 4'b1111, 32'hCAFE_F00D,
                32'h0, 0);

        issue(1, 0, 3'b010, 32'h8000_0030, 32'h0, 32'h0, 1);
        bus_txn("lw_buserr", 0, 32'h8000_0030, 0, 4'b0000, 32'h0,
                32'h1111_2222, 1);

        issue(1, 0, 3'b010, 32'h8000_0006, 32'h0, 32'h0, 1);
        local_err("lw_misalign");

        issue(0, 1, 3'b001, 32'h8000_0003, 32'hFFFF, 32'h0, 1);
        local_err("sh_misalign");

        issue(1, 1, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 1);
        local_err("both_rw");

        issue(0, 0, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 1);
        local_err("neither_rw");

        issue(0, 1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 1);
        local_err("store_f3bu");

        issue(1, 0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1);
        local_err("load_f3_011");

        // Timeout: four silent WAIT cycles, then an error retire.
        issue(1, 0, 3'b010, 32'h8000_0040, 32'h0, 32'h0, 1);
        chk("to_req_valid", {31'd0, bus.req_valid}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_no_wb", {31'd0, wb_valid}, 32'd0);
            chk("to_wait_busy", {31'd0, lsu_busy}, 32'd1);
            @(negedge clk);
        end
        pop_check("timeout");
        @(negedge clk);
        chk("to_wb_pulse", {31'd0, wb_valid}, 32'd0);
        chk("to_idle", {31'd0, lsu_busy}, 32'd0);

        // Reset during WAIT, then a stray response must be ignored.
        sb.push_back('{32'h0, 1'b0});
        void'(sb.pop_back());
        @(negedge clk);
        ex_valid = 1'b1;
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h8000_0050;
        @(negedge clk);
        ex_valid = 1'b0;
        mem_read = 1'b0;
        chk("abort_req_valid", {31'd0, bus.req_valid}, 32'd1);
        @(negedge clk);
        chk("abort_in_wait", {31'd0, bus.req_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_low", {31'd0, bus.req_valid}, 32'd0);
        chk("abort_busy_low", {31'd0, lsu_busy}, 32'd0);
        chk("abort_no_wb", {31'd0, wb_valid}, 32'd0);
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        chk("late_resp_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("late_resp_idle", {31'd0, lsu_busy}, 32'd0);
        @(negedge clk);
        chk("late_resp_no_wb2", {31'd0, wb_valid}, 32'd0);

        // The unit must still work after the abort.
        issue(1, 0, 3'b000, 32'h8000_0061, 32'h0, 32'h0000_0034, 0);
        bus_txn("lb_post_rst", 0, 32'h8000_0060, 0, 4'b0000, 32'h0,
                32'h1234_3412, 0);

        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
